// File: rtl/denise_ham_decoder.sv
// Denise Hold-And-Modify pixel stage (HAM6/HAM8) after the colour table.
// Two-stage pipeline: stage 1 registers pixel/mode, stage 2 merges palette data.
module denise_ham_decoder (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        pix_en,
    input  logic [7:0]  select,
    input  logic        blank,
    input  logic        ham_en,
    input  logic        ham8,
    output logic [7:0]  clut_sel,
    input  logic [23:0] rgb_in,
    output logic [23:0] rgb_out,
    output logic        rgb_valid
);

    logic [1:0]  ctrl_d;
    logic [7:0]  data_d;
    logic        blank_d;
    logic        ham_d;
    logic        ham8_d;
    logic        pix_d;
    logic [23:0] hold;
    logic [23:0] next_rgb;
    logic [7:0]  p_r, p_g, p_b;
    logic [7:0]  mod_r, mod_g, mod_b;

    always_comb begin
        clut_sel = select;
        if (ham_en) begin
            if (ham8) clut_sel = {2'b00, select[7:2]};
            else      clut_sel = {4'b0000, select[3:0]};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctrl_d  <= 2'b00;
            data_d  <= 8'h00;
            blank_d <= 1'b0;
            ham_d   <= 1'b0;
            ham8_d  <= 1'b0;
            pix_d   <= 1'b0;
        end else begin
            if (ham8) begin
                ctrl_d <= select[1:0];
                data_d <= {2'b00, select[7:2]};
            end else begin
                ctrl_d <= select[5:4];
                data_d <= {select[3:0], select[3:0]};
            end
            blank_d <= blank;
            ham_d   <= ham_en;
            ham8_d  <= ham8;
            pix_d   <= pix_en;
        end
    end

    assign p_r = hold[23:16];
    assign p_g = hold[15:8];
    assign p_b = hold[7:0];

    // HAM8 modifies only the top 6 bits; low 2 bits carry over from P
    assign mod_r = ham8_d ? {data_d[5:0], p_r[1:0]} : data_d;
    assign mod_g = ham8_d ? {data_d[5:0], p_g[1:0]} : data_d;
    assign mod_b = ham8_d ? {data_d[5:0], p_b[1:0]} : data_d;

    always_comb begin
        next_rgb = hold;
        if (blank_d) begin
            next_rgb = 24'h000000;
        end else if (!ham_d) begin
            next_rgb = rgb_in;
        end else begin
            unique case (ctrl_d)
                2'b00:   next_rgb = rgb_in;
                2'b01:   next_rgb = {p_r, p_g, mod_b};
                2'b10:   next_rgb = {mod_r, p_g, p_b};
                default: next_rgb = {p_r, mod_g, p_b};
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold      <= 24'h000000;
            rgb_valid <= 1'b0;
        end else begin
            if (pix_d) hold <= next_rgb;
            rgb_valid <= pix_d;
        end
    end

    assign rgb_out = hold;

endmodule
